// File: rtl/apb_pkg.sv
// apb_pkg: shared APB types.
//   addr_t / data_t     : 32-bit APB address and data
//   apb_mst_state_e     : master bridge FSM states
//   apb_req_t           : latched command {write, addr, wdata}
//   apb_rsp_t           : captured result {rdata, err, timeout}
package apb_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  typedef struct packed {
    logic  write;
    addr_t addr;
    data_t wdata;
  } apb_req_t;

  typedef struct packed {
    data_t rdata;
    logic  err;
    logic  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_watchdog.sv
// apb_watchdog: saturating wait-state counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (wins over en)
//   en         : count one more stalled cycle
//   expired    : count has reached TIMEOUT_CYCLES-1 (never set when TIMEOUT_CYCLES=0)
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at TIMEOUT_CYCLES so a stalled count can never wrap back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CW'(TIMEOUT_CYCLES)))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_on
      assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_off
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command stream -> single APB transfer ->
// valid/ready response, with a PREADY watchdog.
//   PCLK, PRESETn                   : clock, async active-low reset
//   req_valid/ready/write/addr/wdata: command channel
//   rsp_valid/ready/rdata/err/timeout: response channel
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA: APB master outputs
//   PREADY/PSLVERR/PRDATA           : APB slave returns
// Every output is a flop; control outputs are decoded from next state so
// they line up with the state they describe.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic  PCLK,
  input  logic  PRESETn,
  input  logic  req_valid,
  output logic  req_ready,
  input  logic  req_write,
  input  addr_t req_addr,
  input  data_t req_wdata,
  output logic  rsp_valid,
  input  logic  rsp_ready,
  output data_t rsp_rdata,
  output logic  rsp_err,
  output logic  rsp_timeout,
  output logic  PSEL,
  output logic  PENABLE,
  output logic  PWRITE,
  output addr_t PADDR,
  output data_t PWDATA,
  input  logic  PREADY,
  input  logic  PSLVERR,
  input  data_t PRDATA
);

  apb_mst_state_e state_q, state_d;
  apb_req_t       req_q, req_d;
  apb_rsp_t       rsp_q, rsp_d;
  logic           psel_q, psel_d;
  logic           penable_q, penable_d;
  logic           req_ready_q, req_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           wd_expired;

  // Count restarts on the SETUP->ACCESS transition and advances on stalls.
  apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clr     (state_q == SETUP),
    .en      ((state_q == ACCESS) && !PREADY),
    .expired (wd_expired)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        // req_ready is 1 throughout IDLE, so valid alone completes the handshake.
        if (req_valid) begin
          req_d   = '{write: req_write, addr: req_addr, wdata: req_wdata};
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY has priority over an expiry in the same cycle.
        if (PREADY) begin
          rsp_d.err     = PSLVERR;
          rsp_d.timeout = 1'b0;
          rsp_d.rdata   = req_q.write ? '0 : PRDATA;
          state_d       = RESP;
        end else if (wd_expired) begin
          rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = req_q.write;
  assign PADDR       = req_q.addr;
  assign PWDATA      = req_q.wdata;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts a simple valid/ready command stream into APB transfers on the `apb_if` bus, and returns each result on a valid/ready response channel. It sits directly upstream of the APB dual-port memory slave and drives its PSEL/PENABLE/PADDR/PWRITE/PWDATA. It consumes PREADY, PSLVERR and PRDATA. A PREADY watchdog aborts transfers to a hung slave.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of consecutive ACCESS cycles with PREADY=0 before abort. 0 disables the watchdog.

Ports:
- `PCLK` in 1: bus clock; all logic on its rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: command present.
- `req_ready` out 1: bridge accepts a command; the handshake completes when both are 1.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `addr_t`: transfer address.
- `req_wdata` in `data_t`: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out `data_t`: read data; 0 for writes and for aborted transfers.
- `rsp_err` out 1: PSLVERR was sampled high, or a timeout occurred.
- `rsp_timeout` out 1: the transfer was aborted by the watchdog.
- `PSEL`, `PENABLE`, `PWRITE` out 1: APB master controls.
- `PADDR` out `addr_t`: APB address.
- `PWDATA` out `data_t`: APB write data.
- `PREADY`, `PSLVERR` in 1: APB slave status.
- `PRDATA` in `data_t`: APB read data.

## Operation
The FSM has four states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- **SETUP**
  - PSEL=1, PENABLE=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1.
  - If PREADY=1:
    - capture PSLVERR into `rsp_err`;
    - for a read, capture PRDATA into `rsp_rdata`;
    - go to RESP.
  - Else, if the watchdog has expired: `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0, go to RESP.
- **RESP**
  - PSEL=0, PENABLE=0, `rsp_valid`=1.
  - Response fields are held stable.
  - On `rsp_ready`=1: go to IDLE.

General rules:
- `req_ready`=0 in SETUP, ACCESS and RESP. Only one transfer is outstanding.
- PADDR, PWRITE and PWDATA are stable from SETUP through the final ACCESS cycle. In other states they hold their last values.
- PSLVERR and PRDATA are ignored unless PREADY=1 in ACCESS.
- If PREADY=1 on the expiry cycle, PREADY wins: a normal completion, no timeout.
- All outputs are registered. There is no combinational path from any input to any output.

## Timing
Reset values:
- PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
- `req_ready`=1 (state IDLE).
- `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0.

Cycle-level timing (cycle 0 = the edge where the command is accepted):
- Cycle 1: PSEL=1. Cycle 2: PENABLE=1.
- PREADY=1 sampled at the end of cycle 2 gives `rsp_valid`=1 in cycle 3.
- Zero-wait transfer: 4 cycles from handshake back to IDLE with `rsp_ready` tied 1. This is the maximum throughput of one transfer per 4 cycles.
- Each PREADY=0 cycle in ACCESS adds one cycle.

Watchdog:
- The counter clears on entry to ACCESS.
- It increments on each ACCESS cycle with PREADY=0.
- Expiry is when the count reaches `TIMEOUT_CYCLES`-1 with PREADY still 0. This makes ACCESS last exactly `TIMEOUT_CYCLES` cycles.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter never wraps.

Reset mid-transfer:
- PSEL and PENABLE drop asynchronously.
- Any pending response is discarded.
- The FSM returns to IDLE.

## Structure
- `addr_t` and `data_t` (32 bits each) already live in `apb_pkg`.
- Add to `apb_pkg`:
  - the `apb_mst_state_e` enum (IDLE, SETUP, ACCESS, RESP);
  - a `apb_req_t` struct {write, addr, wdata};
  - a `apb_rsp_t` struct {rdata, err, timeout}.
- One natural sub-module is `apb_watchdog`: parameterised counter with clear, enable and expired outputs.
- Top level: ports connect to `apb_if` fields. Bench binds via the `driver_dv`-style signals, with the slave model on the slave side.

## Test plan
- **Write, zero wait:**
  - Stimulus: write addr 0x10, data 0xDEADBEEF; PREADY tied 1.
  - Response: PSEL high cycles 1-2, PENABLE high cycle 2; `rsp_valid` cycle 3 with `rsp_err`=0; memory at 0x10 = 0xDEADBEEF.
- **Read, 3 wait states:**
  - Stimulus: read addr 0x10; slave holds PREADY=0 for 3 cycles and returns 0xDEADBEEF.
  - Response: ACCESS lasts 4 cycles; `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- **Slave error:**
  - Stimulus: slave returns PSLVERR=1 with PREADY=1 on a read; PRDATA=0x1234.
  - Response: `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0x1234.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYCLES`=16; PREADY stuck at 0.
  - Response: ACCESS lasts exactly 16 cycles; `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0. PREADY=1 on cycle 16 instead gives a normal completion.
- **Back-pressure:**
  - Stimulus: `rsp_ready`=0 for 5 cycles while `req_valid` is held with the next command.
  - Response: `rsp_valid` and data stay stable; `req_ready` stays 0; the next SETUP starts 2 cycles after `rsp_ready` rises.
- **Reset mid-transfer:**
  - Stimulus: PRESETn pulsed low during ACCESS.
  - Response: PSEL and PENABLE drop 0 immediately; `rsp_valid`=0; `req_ready`=1 after release.
